ebi_cmd_packer: RTL

Assembles the 16-bit host writes arriving over the EBI into 80-bit scheduler commands and pushes each complete command into the command FIFO. Sits between the EBI register interface and `command_fifo`, in the `sys_clk` domain. Owns word ordering, backpressure from a full FIFO, and recovery from partial or aborted commands, so the EBI block only forwards write strobes.

---
 rtl/ebi_cmd_packer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ebi_cmd_packer.sv
`default_nettype none
// ============================================================================
// Module      : ebi_cmd_packer
// Description : Packs 16-bit EBI host writes into CMD_WORDS-word scheduler
//               commands and pushes each complete command into command_fifo.
//               The first word written lands in the LSBs. A complete command
//               is held while the FIFO is full. The block also flags dropped
//               writes and handles recovery from partial or aborted commands.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: CMD_PACKER_TIMEOUT_EN
//   defined   : an idle counter discards a partial command after
//               TIMEOUT_CYCLES idle clocks and sets o_timeout_err.
//   undefined : partial commands persist until they are completed, aborted
//               or reset. o_timeout_err stays 0.
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock (sys_clk)
//   rst            in   synchronous reset, active low
//   i_wr_en        in   one-cycle strobe per host data word
//   i_wr_data      in   host data word, valid with i_wr_en
//   i_abort        in   flush any partial or held command
//   i_err_clr      in   clear the sticky error flags
//   i_fifo_full    in   full flag from command_fifo
//   o_fifo_din     out  assembled command (16*CMD_WORDS bits)
//   o_fifo_wr_en   out  push strobe to command_fifo
//   o_busy         out  a complete command is waiting to be pushed
//   o_word_count   out  number of words staged in the current command
//   o_overflow_err out  sticky: a write arrived while busy and was dropped
//   o_timeout_err  out  sticky: a partial command was discarded on timeout
// ============================================================================
module ebi_cmd_packer #(
    parameter int CMD_WORDS      = 5,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [15:0]             i_wr_data,
    input  logic                    i_abort,
    input  logic                    i_err_clr,
    input  logic                    i_fifo_full,
    output logic [16*CMD_WORDS-1:0] o_fifo_din,
    output logic                    o_fifo_wr_en,
    output logic                    o_busy,
    output logic [2:0]              o_word_count,
    output logic                    o_overflow_err,
    output logic                    o_timeout_err
);

    localparam int       c_DIN_W = 16 * CMD_WORDS;
    localparam logic [2:0] c_LAST = 3'(CMD_WORDS - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_PUSH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_word_count;
    logic [2:0]           w_word_count_nxt;
    logic [2:0]           w_slot;
    logic [c_DIN_W-1:0]   r_din;
    logic [c_DIN_W-1:0]   w_din_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic                 r_tmo;
    logic                 w_tmo_nxt;
    logic                 w_ovf_set;
    logic                 w_expire;

    // ------------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------------
`ifdef CMD_PACKER_TIMEOUT_EN
    localparam int                    c_IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0]   c_IDLE_MAX = c_IDLE_W'(TIMEOUT_CYCLES);

    logic [c_IDLE_W-1:0] r_idle;
    logic [c_IDLE_W-1:0] w_idle_nxt;

    always_comb begin
        // Expiry is the cycle in which the counter already holds the limit.
        // A write in that cycle still starts a new command at slot 0.
        w_expire = (r_state == S_FILL) && (r_word_count != 3'd0) &&
                   (r_idle == c_IDLE_MAX) && !i_abort;
        w_idle_nxt = r_idle + 1'b1;
        if (i_abort || (r_state != S_FILL) || (r_word_count == 3'd0) ||
            i_wr_en || w_expire) begin
            w_idle_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idle <= '0;
        end else begin
            r_idle <= w_idle_nxt;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_word_count_nxt = r_word_count;
        w_din_nxt        = r_din;
        w_ovf_set        = (r_state == S_PUSH) && i_wr_en && !i_abort;
        // A timed-out partial command restarts the slot index at 0.
        w_slot           = w_expire ? 3'd0 : r_word_count;

        if (i_abort) begin
            w_state_nxt      = S_FILL;
            w_word_count_nxt = 3'd0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_expire) begin
                        w_word_count_nxt = 3'd0;
                    end
                    if (i_wr_en) begin
                        for (int k = 0; k < CMD_WORDS; k++) begin
                            if (w_slot == 3'(k)) begin
                                w_din_nxt[16*k +: 16] = i_wr_data;
                            end
                        end
                        if (w_slot == c_LAST) begin
                            w_word_count_nxt = 3'd0;
                            w_state_nxt      = S_PUSH;
                        end else begin
                            w_word_count_nxt = w_slot + 3'd1;
                        end
                    end
                end
                S_PUSH: begin
                    if (!i_fifo_full) begin
                        w_state_nxt = S_FILL;
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                end
            endcase
        end

        // A set in the same cycle as a clear wins.
        w_ovf_nxt = w_ovf_set | (r_ovf & ~i_err_clr);
        w_tmo_nxt = w_expire  | (r_tmo & ~i_err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_FILL;
            r_word_count <= 3'd0;
            r_din        <= '0;
            r_ovf        <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_count <= w_word_count_nxt;
            r_din        <= w_din_nxt;
            r_ovf        <= w_ovf_nxt;
            r_tmo        <= w_tmo_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The push strobe is gated with reset so a reset landing on a push cycle
    // never hands a command to the FIFO.
    assign o_fifo_wr_en   = rst && (r_state == S_PUSH) && !i_fifo_full;
    assign o_busy         = (r_state == S_PUSH);
    assign o_fifo_din     = r_din;
    assign o_word_count   = r_word_count;
    assign o_overflow_err = r_ovf;
    assign o_timeout_err  = r_tmo;

endmodule
`default_nettype wire
